simd_alu_result_stage: RTL and testbench
========================================

Name: simd_alu_result_stage

Overview:
- Registered output stage directly downstream of the SIMD adder.
- Captures the adder's combinational result and per-byte ovf/udf flags through a valid/ready handshake, using a 2-entry skid buffer.
- Optionally saturates overflowing elements per lane, keeps sticky overflow/underflow status, and counts flagged elements.
- Feeds the ALU writeback path.

Parameters:
- SIMD_DATA_WIDTH, 256: vector width in bits; must be a multiple of 64.
- SIMD_ADDER_DATA_MODE_WIDTH, 2: width of the data_mode field; 0=8b, 1=16b, 2=32b, 3=64b elements.
- SAT_CNT_WIDTH, 16: width of the flagged-element counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_result  in  SIMD_DATA_WIDTH  raw adder result.
- in_ovf  in  SIMD_DATA_WIDTH/8  per-byte overflow flags.
- in_udf  in  SIMD_DATA_WIDTH/8  per-byte underflow flags.
- in_data_mode  in  SIMD_ADDER_DATA_MODE_WIDTH  element size of the beat.
- in_data_signed  in  1  beat is signed two's complement.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_result  out  SIMD_DATA_WIDTH  final (possibly saturated) result.
- out_sat  out  SIMD_DATA_WIDTH/8  per-byte flag: this byte belongs to a flagged element.
- clr_status  in  1  synchronous clear of sticky status and counter.
- sticky_ovf  out  1  any overflow seen since the last clear.
- sticky_udf  out  1  any underflow seen since the last clear.
- sat_count  out  SAT_CNT_WIDTH  count of flagged elements since the last clear.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_result=0, out_sat=0, skid empty, sticky_ovf=0, sticky_udf=0, sat_count=0. in_ready=1 from the first clock after reset deassertion. Reset mid-transfer drops both buffered beats; no partial output is produced.
- Handshake:
  - A beat is accepted when in_valid&&in_ready. A beat is delivered when out_valid&&out_ready.
  - in_ready = !skid_valid, driven from a register (no combinational path from out_ready).
  - Latency is 1 cycle: a beat accepted in cycle N appears on out_* in cycle N+1 when the output register is empty or being drained in cycle N.
  - If the output register holds an undelivered beat and a new beat is accepted, the new beat goes to the skid entry. On the next delivery the skid beat moves to the output register.
  - Beats are never dropped, duplicated or reordered. out_* stay stable while out_valid&&!out_ready.
- Element flag computation (done at accept, registered with the beat):
  - The element size is E = 8<<in_data_mode.
  - Element ovf = OR of in_ovf over its E/8 bytes. Element udf is computed the same way from in_udf.
  - out_sat bytes are set for every byte of an element whose ovf or udf is set.
- Saturation (under the optional feature):
  - Unsigned, ovf: element = all ones.
  - Unsigned, udf: element = 0.
  - Signed, ovf: element = max positive (0x7F.., MSB 0, rest 1).
  - Signed, udf: element = min negative (0x80..).
  - ovf and udf both set: ovf wins.
  - Unflagged elements pass in_result unchanged.
- Status (updated on accept, not on delivery):
  - sticky_ovf |= any element ovf; sticky_udf |= any element udf.
  - sat_count += number of flagged elements in the beat, saturating at all ones (no wrap).
  - clr_status in the same cycle as an accept with flags: the clear applies first, then that beat's contribution is added. Status therefore reflects the new beat only.

Optional Feature:
- Macro SIMD_RES_SAT_EN.
- Defined: saturation is applied as described above.
- Undefined: out_result always equals the registered in_result. out_sat, sticky flags and sat_count are still computed identically. Handshake and latency are unchanged.

Test Plan:
- 8b unsigned: byte0 in_result=0x04 with in_ovf[0]=1, out_ready=1 -> next cycle out_result byte0=0xFF, out_sat[0]=1, sticky_ovf=1, sat_count=1 (byte0=0x04 if SIMD_RES_SAT_EN is undefined).
- 16b signed: element0 raw=0x8001, in_ovf[1]=1 -> element0=0x7FFF, out_sat[1:0]=2'b11. Same element with in_udf[0]=1 only -> 0x8000, sticky_udf=1.
- Backpressure: out_ready=0 with 3 consecutive in_valid beats A, B, C -> A in output, B in skid, in_ready=0 in the cycle C is offered. Raise out_ready -> A, B, C delivered in order with no gaps after the first.
- Counter saturation: with SAT_CNT_WIDTH=4, send 4 beats of 32b mode with all 8 elements flagged -> sat_count ends at 15, not wrapped.
- clr_status asserted in the same cycle as an accept with 2 flagged 64b elements -> sat_count=2 next cycle, sticky flags reflect that beat only.
- Assert rst_n low while both entries are full -> out_valid=0, sat_count=0 immediately. in_ready=1 after release, and no stale beat is delivered.

Source files
------------

// File: rtl/simd_alu_result_stage_if.sv
// Beat bus between the SIMD adder, the result stage and the ALU writeback path.
// The stage connects through the slave modport; the producer/consumer side uses master.
interface simd_alu_result_stage_if #(
  parameter int SIMD_DATA_WIDTH            = 256,
  parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [SIMD_DATA_WIDTH-1:0]            in_result;
  logic [SIMD_DATA_WIDTH/8-1:0]          in_ovf;
  logic [SIMD_DATA_WIDTH/8-1:0]          in_udf;
  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] in_data_mode;
  logic                                  in_data_signed;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [SIMD_DATA_WIDTH-1:0]            out_result;
  logic [SIMD_DATA_WIDTH/8-1:0]          out_sat;

  modport master (
    output in_valid, in_result, in_ovf, in_udf, in_data_mode, in_data_signed, out_ready,
    input  in_ready, out_valid, out_result, out_sat
  );

  modport slave (
    input  in_valid, in_result, in_ovf, in_udf, in_data_mode, in_data_signed, out_ready,
    output in_ready, out_valid, out_result, out_sat
  );
endinterface

// File: rtl/simd_alu_result_stage.sv
// Registered result stage behind the SIMD adder: 2-entry skid buffer, per-element flags,
// sticky status and a saturating flagged-element counter. Define SIMD_RES_SAT_EN for lane saturation.
module simd_alu_result_stage #(
  parameter int SIMD_DATA_WIDTH            = 256,
  parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2,
  parameter int SAT_CNT_WIDTH              = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  simd_alu_result_stage_if.slave   bus,
  input  logic                     clr_status,
  output logic                     sticky_ovf,
  output logic                     sticky_udf,
  output logic [SAT_CNT_WIDTH-1:0] sat_count
);
  localparam int NB    = SIMD_DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(NB + 1);
  localparam int SUM_W = ((SAT_CNT_WIDTH > CNT_W) ? SAT_CNT_WIDTH : CNT_W) + 1;

  logic                       in_ready_r, out_valid_r, skid_valid_r, skid_valid_nxt_s;
  logic [SIMD_DATA_WIDTH-1:0] out_result_r, skid_result_r, new_result_s;
  logic [NB-1:0]              out_sat_r, skid_sat_r;
  logic [NB-1:0]              elem_ovf_s, elem_udf_s, lead_s;
  logic [CNT_W-1:0]           cnt_s, cnt_add_s;
  logic [SAT_CNT_WIDTH-1:0]   sat_count_r, cnt_base_s, cnt_nxt_s;
  logic [SUM_W-1:0]           cnt_sum_s;
  logic                       sticky_ovf_r, sticky_udf_r, accept_s;

  assign accept_s = bus.in_valid && in_ready_r;

  // Broadcast each element's OR-reduced flags to all of its bytes and count flagged elements.
  always_comb begin
    elem_ovf_s = '0;
    elem_udf_s = '0;
    lead_s     = '0;
    cnt_s      = '0;
    for (int b = 0; b < NB; b++) begin
      case (bus.in_data_mode)
        2'd1: begin
          elem_ovf_s[b] = |bus.in_ovf[{b[31:1], 1'b0} +: 2];
          elem_udf_s[b] = |bus.in_udf[{b[31:1], 1'b0} +: 2];
          lead_s[b]     = (b[0] == 1'b0);
        end
        2'd2: begin
          elem_ovf_s[b] = |bus.in_ovf[{b[31:2], 2'b00} +: 4];
          elem_udf_s[b] = |bus.in_udf[{b[31:2], 2'b00} +: 4];
          lead_s[b]     = (b[1:0] == 2'b00);
        end
        2'd3: begin
          elem_ovf_s[b] = |bus.in_ovf[{b[31:3], 3'b000} +: 8];
          elem_udf_s[b] = |bus.in_udf[{b[31:3], 3'b000} +: 8];
          lead_s[b]     = (b[2:0] == 3'b000);
        end
        default: begin
          elem_ovf_s[b] = bus.in_ovf[b];
          elem_udf_s[b] = bus.in_udf[b];
          lead_s[b]     = 1'b1;
        end
      endcase
      cnt_s = cnt_s + {{(CNT_W-1){1'b0}}, lead_s[b] & (elem_ovf_s[b] | elem_udf_s[b])};
    end
  end

`ifdef SIMD_RES_SAT_EN
  // Byte-wise clamp: only the element's top byte differs between signed and unsigned limits.
  always_comb begin
    new_result_s = bus.in_result;
    for (int b = 0; b < NB; b++) begin
      logic msb_v;
      case (bus.in_data_mode)
        2'd1:    msb_v = (b[0] == 1'b1);
        2'd2:    msb_v = (b[1:0] == 2'b11);
        2'd3:    msb_v = (b[2:0] == 3'b111);
        default: msb_v = 1'b1;
      endcase
      if (elem_ovf_s[b]) begin
        new_result_s[{b[28:0], 3'b000} +: 8] = (bus.in_data_signed && msb_v) ? 8'h7F : 8'hFF;
      end else if (elem_udf_s[b]) begin
        new_result_s[{b[28:0], 3'b000} +: 8] = (bus.in_data_signed && msb_v) ? 8'h80 : 8'h00;
      end else begin
        new_result_s[{b[28:0], 3'b000} +: 8] = bus.in_result[{b[28:0], 3'b000} +: 8];
      end
    end
  end
`else
  assign new_result_s = bus.in_result;
`endif

  // The skid entry stays occupied only while the output register is stalled.
  always_comb begin
    if (out_valid_r && !bus.out_ready) begin
      skid_valid_nxt_s = skid_valid_r || accept_s;
    end else begin
      skid_valid_nxt_s = 1'b0;
    end
  end

  // Output register and skid entry; a skid beat always drains before a fresh one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_result_r  <= '0;
      out_sat_r     <= '0;
      skid_valid_r  <= 1'b0;
      skid_result_r <= '0;
      skid_sat_r    <= '0;
    end else begin
      in_ready_r   <= !skid_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      if (!out_valid_r || bus.out_ready) begin
        if (skid_valid_r) begin
          out_valid_r  <= 1'b1;
          out_result_r <= skid_result_r;
          out_sat_r    <= skid_sat_r;
        end else if (accept_s) begin
          out_valid_r  <= 1'b1;
          out_result_r <= new_result_s;
          out_sat_r    <= elem_ovf_s | elem_udf_s;
        end else begin
          out_valid_r  <= 1'b0;
        end
      end else if (accept_s) begin
        skid_result_r <= new_result_s;
        skid_sat_r    <= elem_ovf_s | elem_udf_s;
      end
    end
  end

  // Counter next value: a same-cycle clear zeroes the base before this beat is added.
  always_comb begin
    if (clr_status) begin
      cnt_base_s = '0;
    end else begin
      cnt_base_s = sat_count_r;
    end
    if (accept_s) begin
      cnt_add_s = cnt_s;
    end else begin
      cnt_add_s = '0;
    end
    cnt_sum_s = {{(SUM_W-SAT_CNT_WIDTH){1'b0}}, cnt_base_s} + {{(SUM_W-CNT_W){1'b0}}, cnt_add_s};
    if (cnt_sum_s[SUM_W-1:SAT_CNT_WIDTH] != '0) begin
      cnt_nxt_s = '1;
    end else begin
      cnt_nxt_s = cnt_sum_s[SAT_CNT_WIDTH-1:0];
    end
  end

  // Sticky status and flagged-element counter, updated on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf_r <= 1'b0;
      sticky_udf_r <= 1'b0;
      sat_count_r  <= '0;
    end else begin
      sticky_ovf_r <= (sticky_ovf_r && !clr_status) || (accept_s && (|elem_ovf_s));
      sticky_udf_r <= (sticky_udf_r && !clr_status) || (accept_s && (|elem_udf_s));
      sat_count_r  <= cnt_nxt_s;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = out_result_r;
  assign bus.out_sat    = out_sat_r;
  assign sticky_ovf     = sticky_ovf_r;
  assign sticky_udf     = sticky_udf_r;
  assign sat_count      = sat_count_r;
endmodule

// File: tb/tb_simd_alu_result_stage.sv
// Randomized self-checking bench for simd_alu_result_stage against an element-level queue model.
// Expectations follow SIMD_RES_SAT_EN the same way the design does.
module tb_simd_alu_result_stage;
  typedef struct {
    logic [255:0] res;
    logic [31:0]  sat;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       clr_status;
  logic       sticky_ovf, sticky_udf;
  logic [3:0] sat_count;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  bit    m_ready, m_ovf, m_udf;
  int    m_cnt;

  simd_alu_result_stage_if #(.SIMD_DATA_WIDTH(256), .SIMD_ADDER_DATA_MODE_WIDTH(2)) bus ();

  simd_alu_result_stage #(
    .SIMD_DATA_WIDTH(256), .SIMD_ADDER_DATA_MODE_WIDTH(2), .SAT_CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr_status(clr_status),
    .sticky_ovf(sticky_ovf), .sticky_udf(sticky_udf), .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: walk the beat element by element with plain arithmetic on the element value.
  task automatic model_beat(input logic [255:0] r, input logic [31:0] o, input logic [31:0] u,
                            input logic [1:0] mode, input bit sgn,
                            output beat_t bt, output int nflag, output bit ao, output bit au);
    int nb;
    logic [63:0] emax, ev;
    bit eo, eu;
    nb = 1 << mode;
    emax = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    bt.res = r; bt.sat = '0; nflag = 0; ao = 0; au = 0; ev = '0;
    for (int e = 0; e < 32 / nb; e++) begin
      eo = 0; eu = 0;
      for (int k = 0; k < nb; k++) begin
        eo = eo | o[e*nb+k];
        eu = eu | u[e*nb+k];
      end
      ao = ao | eo; au = au | eu;
      if (eo || eu) begin
        nflag++;
        for (int k = 0; k < nb; k++) bt.sat[e*nb+k] = 1'b1;
`ifdef SIMD_RES_SAT_EN
        if (eo) ev = sgn ? (emax >> 1) : emax;
        else    ev = sgn ? ((emax >> 1) + 64'd1) : 64'd0;
        for (int k = 0; k < nb; k++) bt.res[(e*nb+k)*8 +: 8] = ev[k*8 +: 8];
`endif
      end
    end
  endtask

  // Drive one cycle from a falling edge and advance the model across the rising edge.
  task automatic step(input bit v, input logic [255:0] r, input logic [31:0] o, input logic [31:0] u,
                      input logic [1:0] mode, input bit sgn, input bit ordy, input bit clr);
    beat_t bt, popped;
    int nf;
    bit ao, au, acc, del;
    bus.in_valid = v; bus.in_result = r; bus.in_ovf = o; bus.in_udf = u;
    bus.in_data_mode = mode; bus.in_data_signed = sgn; bus.out_ready = ordy; clr_status = clr;
    acc = v && m_ready;
    del = (exp_q.size() > 0) && ordy;
    model_beat(r, o, u, mode, sgn, bt, nf, ao, au);
    @(posedge clk);
    if (del) popped = exp_q.pop_front();
    if (acc) exp_q.push_back(bt);
    if (clr) begin m_ovf = 0; m_udf = 0; m_cnt = 0; end
    if (acc) begin
      m_ovf = m_ovf | ao; m_udf = m_udf | au;
      m_cnt = (m_cnt + nf > 15) ? 15 : m_cnt + nf;
    end
    m_ready = (exp_q.size() < 2);
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, '0, '0, 2'd0, 1'b0, ordy, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr_status = 1'b0;
    bus.in_valid = 1'b0; bus.in_result = '0; bus.in_ovf = '0; bus.in_udf = '0;
    bus.in_data_mode = 2'd0; bus.in_data_signed = 1'b0; bus.out_ready = 1'b0;
    exp_q.delete(); m_ready = 0; m_ovf = 0; m_udf = 0; m_cnt = 0;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_result !== 256'd0) begin errors++; $display("FAIL reset_out_result: got %h want 0", bus.out_result); end
    checks++; if (bus.out_sat !== 32'd0) begin errors++; $display("FAIL reset_out_sat: got %h want 0", bus.out_sat); end
    checks++; if ({sticky_ovf, sticky_udf} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %b%b want 00", sticky_ovf, sticky_udf); end
    checks++; if (sat_count !== 4'd0) begin errors++; $display("FAIL reset_sat_count: got %0d want 0", sat_count); end
    rst_n = 1'b1;
    idle(1'b1);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_8b_unsigned();
    logic [255:0] r;
    logic [7:0] exp_b0;
`ifdef SIMD_RES_SAT_EN
    exp_b0 = 8'hFF;
`else
    exp_b0 = 8'h04;
`endif
    r = rand256(); r[7:0] = 8'h04;
    step(1'b1, r, 32'h1, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL u8_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_result[7:0] !== exp_b0) begin errors++; $display("FAIL u8_byte0: got %h want %h", bus.out_result[7:0], exp_b0); end
    checks++; if (bus.out_result !== exp_q[0].res) begin errors++; $display("FAIL u8_result: got %h want %h", bus.out_result, exp_q[0].res); end
    checks++; if (bus.out_sat !== 32'h1) begin errors++; $display("FAIL u8_sat: got %h want 00000001", bus.out_sat); end
    checks++; if (sticky_ovf !== 1'b1 || sticky_udf !== 1'b0) begin errors++; $display("FAIL u8_sticky: got %b%b want 10", sticky_ovf, sticky_udf); end
    checks++; if (sat_count !== 4'd1) begin errors++; $display("FAIL u8_count: got %0d want 1", sat_count); end
    idle(1'b1);
  endtask

  task automatic test_16b_signed();
    logic [255:0] r;
    logic [15:0] exp_o, exp_u;
`ifdef SIMD_RES_SAT_EN
    exp_o = 16'h7FFF; exp_u = 16'h8000;
`else
    exp_o = 16'h8001; exp_u = 16'h8001;
`endif
    r = rand256(); r[15:0] = 16'h8001;
    step(1'b1, r, 32'h2, 32'h0, 2'd1, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.out_result[15:0] !== exp_o) begin errors++; $display("FAIL s16_ovf_elem: got %h want %h", bus.out_result[15:0], exp_o); end
    checks++; if (bus.out_sat !== 32'h3) begin errors++; $display("FAIL s16_ovf_sat: got %h want 00000003", bus.out_sat); end
    step(1'b1, r, 32'h0, 32'h1, 2'd1, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.out_result[15:0] !== exp_u) begin errors++; $display("FAIL s16_udf_elem: got %h want %h", bus.out_result[15:0], exp_u); end
    checks++; if (bus.out_result !== exp_q[0].res) begin errors++; $display("FAIL s16_udf_result: got %h want %h", bus.out_result, exp_q[0].res); end
    checks++; if (sticky_udf !== 1'b1 || sticky_ovf !== 1'b1) begin errors++; $display("FAIL s16_sticky: got %b%b want 11", sticky_ovf, sticky_udf); end
    checks++; if (sat_count !== 4'd2) begin errors++; $display("FAIL s16_count: got %0d want 2", sat_count); end
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    logic [255:0] a, b, c;
    a = rand256(); b = rand256(); c = rand256();
    step(1'b1, a, '0, '0, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, b, '0, '0, 2'd2, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_result !== a) begin errors++; $display("FAIL bp_hold_a: got %h want %h", bus.out_result, a); end
    step(1'b1, c, '0, '0, 2'd2, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== a) begin errors++; $display("FAIL bp_stable_a: got %b/%h want 1/%h", bus.out_valid, bus.out_result, a); end
    step(1'b1, c, '0, '0, 2'd2, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== b) begin errors++; $display("FAIL bp_deliver_b: got %b/%h want 1/%h", bus.out_valid, bus.out_result, b); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_again: got %b want 1", bus.in_ready); end
    step(1'b1, c, '0, '0, 2'd2, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== c) begin errors++; $display("FAIL bp_deliver_c: got %b/%h want 1/%h", bus.out_valid, bus.out_result, c); end
    idle(1'b1);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_counter_sat();
    logic [31:0] o;
    step(1'b0, '0, '0, '0, 2'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      o = $urandom & 32'h1111_1111;
      step(1'b1, rand256(), o, ~o & 32'h1111_1111, 2'd2, 1'(i % 2), 1'b1, 1'b0);
      checks++;
      if (sat_count !== 4'((8 * i > 15) ? 15 : 8 * i)) begin
        errors++; $display("FAIL cnt_sat_beat%0d: got %0d want %0d", i, sat_count, (8 * i > 15) ? 15 : 8 * i);
      end
    end
    idle(1'b1);
  endtask

  task automatic test_clr_same_cycle();
    step(1'b1, rand256(), 32'h0, 32'h3, 2'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (sticky_udf !== 1'b1) begin errors++; $display("FAIL clr_pre_udf: got %b want 1", sticky_udf); end
    step(1'b1, rand256(), 32'h0000_0101, 32'h0, 2'd3, 1'b1, 1'b1, 1'b1);
    checks++; if (sat_count !== 4'd2) begin errors++; $display("FAIL clr_count: got %0d want 2", sat_count); end
    checks++; if (sticky_ovf !== 1'b1 || sticky_udf !== 1'b0) begin errors++; $display("FAIL clr_sticky: got %b%b want 10", sticky_ovf, sticky_udf); end
    checks++; if (bus.out_sat !== 32'h0000_FFFF) begin errors++; $display("FAIL clr_sat: got %h want 0000ffff", bus.out_sat); end
    checks++; if (bus.out_result !== exp_q[0].res) begin errors++; $display("FAIL clr_result: got %h want %h", bus.out_result, exp_q[0].res); end
    idle(1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (bus.in_ready !== m_ready) begin errors++; $display("FAIL rnd_in_ready @%0d: got %b want %b", i, bus.in_ready, m_ready); end
      checks++;
      if (bus.out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_out_valid @%0d: got %b want %b", i, bus.out_valid, exp_q.size() > 0); end
      if (exp_q.size() > 0) begin
        checks++;
        if (bus.out_result !== exp_q[0].res || bus.out_sat !== exp_q[0].sat) begin
          errors++; $display("FAIL rnd_beat @%0d: got %h/%h want %h/%h", i, bus.out_result, bus.out_sat, exp_q[0].res, exp_q[0].sat);
        end
      end
      checks++;
      if (sticky_ovf !== m_ovf || sticky_udf !== m_udf || sat_count !== 4'(m_cnt)) begin
        errors++; $display("FAIL rnd_status @%0d: got %b%b/%0d want %b%b/%0d", i, sticky_ovf, sticky_udf, sat_count, m_ovf, m_udf, m_cnt);
      end
      step($urandom_range(0, 3) != 0, rand256(), $urandom & $urandom & $urandom, $urandom & $urandom & $urandom,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (3) idle(1'b1);
  endtask

  task automatic test_reset_mid();
    step(1'b1, rand256(), 32'hFFFF_FFFF, '0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, rand256(), 32'hFFFF_FFFF, '0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_full: got rdy %b vld %b want 0 1", bus.in_ready, bus.out_valid); end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.out_valid); end
    checks++; if (sat_count !== 4'd0 || sticky_ovf !== 1'b0) begin errors++; $display("FAIL rstmid_status: got %0d/%b want 0/0", sat_count, sticky_ovf); end
    exp_q.delete(); m_ready = 0; m_ovf = 0; m_udf = 0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale @%0d: got %b want 0", i, bus.out_valid); end
      idle(1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_8b_unsigned();
    test_16b_signed();
    test_backpressure();
    test_counter_sat();
    test_clr_same_cycle();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
